bg_rom_arbiter: RTL and testbench

Two-port arbiter that shares one background tile ROM (32x32 texels, 12-bit RGB, one-cycle registered-address read) between two read clients. Port 0 is the VGA pixel path and has priority. Port 1 is a secondary reader, such as a HUD or framebuffer pre-fill. The block sits between the clients and the ROM instance. It grants at most one read per cycle, drives the ROM address, and returns the texel to the winning port through a tagged response pipeline with fixed latency.

---
 rtl/bg_rom_arbiter.sv | 150 +++++++++++++++
 tb/tb_bg_rom_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bg_rom_arbiter.sv
// bg_rom_arbiter: shares one 32x32 12-bit background tile ROM between a
// priority pixel port (port 0) and a secondary reader (port 1). Grants are
// combinational, the ROM address holds its last granted value when idle, and
// responses come back through a 2-stage tagged pipeline with fixed latency.
// Optional feature macro: BG_ARB_STARVE_GUARD_EN (port-1 starvation guard).
module bg_rom_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_row,
  input  logic [4:0]  req0_col,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_row,
  input  logic [4:0]  req1_col,
  output logic        req1_ready,
  output logic [4:0]  rom_row,
  output logic [4:0]  rom_col,
  input  logic [11:0] rom_data,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [11:0] rsp_data
);

  logic       grant0_s;
  logic       grant1_s;
  logic       force1_s;
  logic [4:0] last_row_r;
  logic [4:0] last_col_r;
  logic       tag_valid_r;
  logic       tag_port_r;

`ifdef BG_ARB_STARVE_GUARD_EN
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0] wait_cnt_r;

  // Guard fires on the cycle the wait counter reaches the tolerated limit.
  always_comb begin
    force1_s = req1_valid && (wait_cnt_r == MAX_WAIT_C);
  end

  // Count consecutive port-1 losses; any port-1 accept or idle clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= 8'd0;
    end else if (!req1_valid || grant1_s) begin
      wait_cnt_r <= 8'd0;
    end else if (wait_cnt_r != 8'hFF) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  logic [7:0] unused_max_wait_s;

  // Pure fixed priority: the guard never fires and MAX_WAIT has no effect.
  always_comb begin
    force1_s          = 1'b0;
    unused_max_wait_s = 8'(MAX_WAIT);
  end
`endif

  // Fixed-priority grant (port 0 first) with optional guard override; no grants in reset.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (force1_s) begin
      grant1_s = 1'b1;
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Readys mirror the grants in the same cycle.
  always_comb begin
    req0_ready = grant0_s;
    req1_ready = grant1_s;
  end

  // Address mux: winner's address, else hold the last granted address.
  always_comb begin
    rom_row = last_row_r;
    rom_col = last_col_r;
    if (grant0_s) begin
      rom_row = req0_row;
      rom_col = req0_col;
    end else if (grant1_s) begin
      rom_row = req1_row;
      rom_col = req1_col;
    end else begin
      rom_row = last_row_r;
      rom_col = last_col_r;
    end
  end

  // Remember the last accepted address so an idle ROM address does not toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_row_r <= 5'd0;
      last_col_r <= 5'd0;
    end else if (grant0_s || grant1_s) begin
      last_row_r <= rom_row;
      last_col_r <= rom_col;
    end else begin
      last_row_r <= last_row_r;
      last_col_r <= last_col_r;
    end
  end

  // Stage 1: tag each accept with the winning port while the ROM reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_r <= 1'b0;
      tag_port_r  <= 1'b0;
    end else begin
      tag_valid_r <= grant0_s || grant1_s;
      tag_port_r  <= grant1_s;
    end
  end

  // Stage 2: register ROM data and steer the response pulse to the tagged port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data   <= 12'h000;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= tag_valid_r && !tag_port_r;
      rsp1_valid <= tag_valid_r && tag_port_r;
      if (tag_valid_r) begin
        rsp_data <= rom_data;
      end else begin
        rsp_data <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Directed testbench for bg_rom_arbiter with a behavioural registered ROM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expectations follow BG_ARB_STARVE_GUARD_EN when defined.
module tb_bg_rom_arbiter;

  localparam bit GUARD =
`ifdef BG_ARB_STARVE_GUARD_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid;
  logic [4:0]  req0_row;
  logic [4:0]  req0_col;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_row;
  logic [4:0]  req1_col;
  logic        req1_ready;
  logic [4:0]  rom_row;
  logic [4:0]  rom_col;
  logic [11:0] rom_data = 12'h000;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [11:0] rsp_data;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  bg_rom_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_row(req0_row), .req0_col(req0_col), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_row(req1_row), .req1_col(req1_col), .req1_ready(req1_ready),
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // ROM contents: a few fixed texels, otherwise {2'b10, row, col}.
  function automatic logic [11:0] texel(input logic [4:0] r, input logic [4:0] c);
    logic [9:0] a;
    a = {r, c};
    case (a)
      10'd0:   return 12'h6DE;
      10'd1:   return 12'h000;
      10'd2:   return 12'h000;
      10'd18:  return 12'hCCD;
      default: return {2'b10, r, c};
    endcase
  endfunction

  // One-cycle registered-address ROM.
  always @(posedge clk) rom_data <= texel(rom_row, rom_col);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_row = 5'd0; req0_col = 5'd0;
    req1_valid = 1'b1; req1_row = 5'd0; req1_col = 5'd0;

    // Reset: readys gated, registers at reset values
    @(negedge clk);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    nxt();
    @(negedge clk);
    check("rst_rom_row", rom_row, 5'd0);
    check("rst_rom_col", rom_col, 5'd0);
    check("rst_rsp0", rsp0_valid, 1'b0);
    check("rst_rsp1", rsp1_valid, 1'b0);
    check("rst_data", rsp_data, 12'h000);
    req0_valid = 1'b0; req1_valid = 1'b0;
    nxt();
    reset = 1'b0;

    // Test 1: single port-0 read of (0,0)
    req0_valid = 1'b1; req0_row = 5'd0; req0_col = 5'd0;
    @(negedge clk);
    check("t1_ready0", req0_ready, 1'b1);
    check("t1_ready1", req1_ready, 1'b0);
    nxt(); req0_valid = 1'b0;
    @(negedge clk);
    check("t1_rsp0_early", rsp0_valid, 1'b0);
    nxt();
    @(negedge clk);
    check("t1_rsp0", rsp0_valid, 1'b1);
    check("t1_data", rsp_data, 12'h6DE);
    check("t1_rsp1", rsp1_valid, 1'b0);
    nxt();
    @(negedge clk);
    check("t1_rsp0_end", rsp0_valid, 1'b0);
    check("t1_data_hold", rsp_data, 12'h6DE);

    // Test 2: port-1 back-to-back (0,1), (0,2), (0,18)
    nxt();
    req1_valid = 1'b1; req1_row = 5'd0; req1_col = 5'd1;
    @(negedge clk);
    check("t2_ready1_a", req1_ready, 1'b1);
    check("t2_col_a", rom_col, 5'd1);
    nxt(); req1_col = 5'd2;
    @(negedge clk);
    check("t2_ready1_b", req1_ready, 1'b1);
    check("t2_col_b", rom_col, 5'd2);
    nxt(); req1_col = 5'd18;
    @(negedge clk);
    check("t2_ready1_c", req1_ready, 1'b1);
    check("t2_col_c", rom_col, 5'd18);
    check("t2_rsp1_a", rsp1_valid, 1'b1);
    check("t2_data_a", rsp_data, 12'h000);
    nxt(); req1_valid = 1'b0;
    @(negedge clk);
    check("t2_rsp1_b", rsp1_valid, 1'b1);
    check("t2_data_b", rsp_data, 12'h000);
    check("t2_hold_col", rom_col, 5'd18);
    nxt();
    @(negedge clk);
    check("t2_rsp1_c", rsp1_valid, 1'b1);
    check("t2_data_c", rsp_data, 12'hCCD);
    check("t2_rsp0", rsp0_valid, 1'b0);
    nxt();
    @(negedge clk);
    check("t2_rsp1_end", rsp1_valid, 1'b0);

    // Test 3: both valid 3 cycles, port 0 (1,1) wins, then port 1 (3,4)
    nxt();
    req0_valid = 1'b1; req0_row = 5'd1; req0_col = 5'd1;
    req1_valid = 1'b1; req1_row = 5'd3; req1_col = 5'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_ready0", req0_ready, 1'b1);
      check("t3_ready1", req1_ready, 1'b0);
      if (i == 2) begin
        check("t3_rsp0_a", rsp0_valid, 1'b1);
        check("t3_data_a", rsp_data, 12'h821);
      end
      nxt();
    end
    req0_valid = 1'b0;
    @(negedge clk);
    check("t3_ready1_win", req1_ready, 1'b1);
    check("t3_ready0_idle", req0_ready, 1'b0);
    check("t3_rom_row", rom_row, 5'd3);
    check("t3_rom_col", rom_col, 5'd4);
    check("t3_rsp0_b", rsp0_valid, 1'b1);
    nxt(); req1_valid = 1'b0;
    @(negedge clk);
    check("t3_rsp0_c", rsp0_valid, 1'b1);
    check("t3_rsp1_c", rsp1_valid, 1'b0);
    nxt();
    @(negedge clk);
    check("t3_rsp1_d", rsp1_valid, 1'b1);
    check("t3_rsp0_d", rsp0_valid, 1'b0);
    check("t3_data_d", rsp_data, 12'h864);

    // Test 4: continuous contention, MAX_WAIT=4
    nxt();
    req0_valid = 1'b1; req0_row = 5'd7; req0_col = 5'd7;
    req1_valid = 1'b1; req1_row = 5'd8; req1_col = 5'd8;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("t4_ready1", req1_ready, GUARD && (i % 5 == 0));
      check("t4_ready0", req0_ready, !(GUARD && (i % 5 == 0)));
      nxt();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    nxt(); nxt(); nxt();

    // Test 5: accept (5,6) on port 0 then reset for one cycle
    req0_valid = 1'b1; req0_row = 5'd5; req0_col = 5'd6;
    @(negedge clk);
    check("t5_ready0", req0_ready, 1'b1);
    nxt(); reset = 1'b1;
    @(negedge clk);
    check("t5_ready0_rst", req0_ready, 1'b0);
    nxt(); reset = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    check("t5_rsp0", rsp0_valid, 1'b0);
    check("t5_rsp1", rsp1_valid, 1'b0);
    check("t5_data", rsp_data, 12'h000);
    check("t5_rom_row", rom_row, 5'd0);
    check("t5_rom_col", rom_col, 5'd0);
    nxt();
    @(negedge clk);
    check("t5_rsp0_late", rsp0_valid, 1'b0);

    // Test 6: accept (2,3), then 10 idle cycles
    nxt();
    req0_valid = 1'b1; req0_row = 5'd2; req0_col = 5'd3;
    @(negedge clk);
    check("t6_ready0", req0_ready, 1'b1);
    nxt(); req0_valid = 1'b0; req0_row = 5'd9; req0_col = 5'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_rom_row", rom_row, 5'd2);
      check("t6_rom_col", rom_col, 5'd3);
      if (rsp0_valid) pulses++;
      if (rsp1_valid) pulses++;
      nxt();
    end
    check("t6_pulses", pulses, 1);
    check("t6_data", rsp_data, 12'h843);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
